mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data bus, in parallel with the data RAM. Decodes the core's store bus (MemWrite, ALU-result address, WriteData), queues bytes in an internal FIFO and serializes them 8N1 on a single `tx` line. Exposes a status word with the same one-cycle read latency as the synchronous data RAM, so the top-level read mux can select it transparently.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0400, byte address of the DATA register; STATUS is at BASE_ADDR+4
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 8, byte entries; power of two, 2..64

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- MemWrite  input  1  store strobe from the core
- DataAdr  input  32  byte address (ALU result)
- WriteData  input  32  store data; only [7:0] is used for DATA
- RdData  output  32  registered read data for STATUS; zero otherwise
- sel  output  1  registered: previous cycle's DataAdr hit DATA or STATUS (read-mux select)
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame is in flight or the FIFO is non-empty

## Operation
- Decode: hit_data = (DataAdr == BASE_ADDR); hit_stat = (DataAdr == BASE_ADDR+4); full 32-bit compare, no aliasing.
- Push: MemWrite & hit_data & !full → WriteData[7:0] enqueued. MemWrite & hit_data & full → byte dropped, overflow sticky set. Fullness is evaluated at cycle start; a pop in the same cycle does not make room.
- Overflow clear: MemWrite & hit_stat clears overflow (data ignored). Set and clear in the same cycle is impossible (different addresses).
- STATUS word: [0] busy, [1] full, [2] empty, [3] overflow, [10:4] fill count (0..FIFO_DEPTH), [31:11] zero.
- TX FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, baud counter←0, → START.
  - START: tx=0 for BAUD_DIV cycles → DATA, bit index←0.
  - DATA: tx=shift[0], LSB first; each BAUD_DIV cycles shift right, index+1; after bit 7 → STOP.
  - STOP: tx=1 for BAUD_DIV cycles → IDLE.
- Baud counter counts 0..BAUD_DIV-1 and wraps; state/bit advances on the wrap cycle. Counter width $clog2(BAUD_DIV).
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide; wrap uses the extra MSB to distinguish full from empty.

## Timing
- Reset values: tx=1, busy=0, sel=0, RdData=0, state IDLE, FIFO empty, overflow=0, counters 0. Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously.
- Push at edge N: count/empty update after N; busy high after N.
- FSM pops at edge N+1; tx falls after N+1. Write-to-start-bit latency: 2 cycles.
- Frame: exactly 10·BAUD_DIV cycles from tx fall to end of stop bit.
- Back-to-back frames: one IDLE cycle between end of STOP and next START (frame pitch 10·BAUD_DIV+1).
- Read: STATUS sampled at edge N for DataAdr presented in cycle N-1; RdData/sel valid in cycle N, matching RAM latency. Count in RdData reflects state before any push/pop at that edge.
- busy falls on the edge that leaves STOP with the FIFO empty.

## Structure
- Package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), STATUS bit-index constants, DATA/STATUS address offsets (0, 4).
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, din, dout, full, empty, count; async active-high reset). Top holds decode, status register, baud counter and TX FSM.

## Test plan
- Reset: assert reset mid-frame → tx=1, busy=0, STATUS read returns 32'h0000_0004 (empty only).
- Single byte 8'hA5, BAUD_DIV=4: tx falls 2 cycles after store, line carries 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; busy drops after 40 cycles.
- Burst: 3 back-to-back stores 8'h01,8'h02,8'h03 → three frames, pitch 41 cycles at BAUD_DIV=4, bytes in order.
- Overflow: with FSM stalled in first frame, 10 stores, FIFO_DEPTH=8 → 1 in flight, 8 queued, 1 dropped; STATUS = full, overflow, count 8; store to STATUS clears bit 3 only.
- Push at full with simultaneous pop: byte dropped, overflow set, count stays 8→7.
- Decode: store to BASE_ADDR+8 and BASE_ADDR-4 → no push, sel=0, RdData=0; read of STATUS → sel=1 exactly one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam int ST_BUSY = 0;
   localparam int ST_FULL = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF = 3;
   localparam int ST_CNT = 4;
   localparam logic [31:0] OFF_DATA = 32'd0;
   localparam logic [31:0] OFF_STAT = 32'd4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic we, re;
   assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign empty = wp == rp;
   assign count = wp - rp;
   assign we = push & !full;
   assign re = pop & !empty;
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (we) wp <= wp + 1'b1;
         if (re) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (we) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus mapped 8N1 transmitter with FIFO and a RAM-latency STATUS read port.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int BAUD_DIV = 434,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] RdData,
   output logic        sel,
   output logic        tx,
   output logic        busy
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic hit_data, hit_stat, full, empty, pop, ovf, wrap, unused;
   logic [AW:0] count;
   logic [7:0] dout, shift, shift_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [31:0] status;
   state_t state, state_n;
   assign hit_data = DataAdr == BASE_ADDR + OFF_DATA;
   assign hit_stat = DataAdr == BASE_ADDR + OFF_STAT;
   assign unused = ^WriteData[31:8];
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(MemWrite & hit_data), .pop(pop),
      .din(WriteData[7:0]), .dout(dout), .full(full), .empty(empty), .count(count)
   );
   assign busy = state != IDLE || !empty;
   assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
   assign wrap = cnt == CW'(BAUD_DIV - 1);
   always_comb begin
      status = '0;
      status[ST_BUSY] = busy;
      status[ST_FULL] = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF] = ovf;
      status[ST_CNT +: 7] = 7'(count);
   end
   // Bus side: STATUS is registered so it lines up with the synchronous RAM read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RdData <= '0;
         sel <= 1'b0;
         ovf <= 1'b0;
      end else begin
         RdData <= hit_stat ? status : '0;
         sel <= hit_data | hit_stat;
         if (MemWrite & hit_data & full) ovf <= 1'b1;
         else if (MemWrite & hit_stat) ovf <= 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         shift <= shift_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      idx_n = idx;
      shift_n = shift;
      pop = 1'b0;
      if (state == IDLE) begin
         if (!empty) begin
            pop = 1'b1;
            shift_n = dout;
            cnt_n = '0;
            state_n = START;
         end
      end else begin
         cnt_n = wrap ? '0 : cnt + 1'b1;
         if (wrap) begin
            unique case (state)
               START: begin
                  state_n = DATA;
                  idx_n = '0;
               end
               DATA: begin
                  shift_n = shift >> 1;
                  idx_n = idx + 1'b1;
                  if (idx == 3'd7) state_n = STOP;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stores/reads; scoreboard queues hold expected frames and STATUS reads.
module tb_mmio_uart_tx;
   localparam logic [31:0] D = 32'h0000_0400;
   localparam logic [31:0] S = 32'h0000_0404;
   typedef struct {logic [7:0] d; int c;} frm_t;
   typedef struct {logic [31:0] v; int c;} rd_t;
   logic clk = 0, reset, MemWrite, sel, tx, busy;
   logic [31:0] DataAdr, WriteData, RdData;
   int cyc = 0, checks = 0, failures = 0, m;
   frm_t txq[$];
   rd_t rdq[$];
   mmio_uart_tx #(.BASE_ADDR(D), .BAUD_DIV(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .RdData(RdData), .sel(sel), .tx(tx), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at cyc %0d", name, got, exp, cyc);
      end
   endtask
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWrite = we;
      DataAdr = a;
      WriteData = d;
   endtask
   task automatic idle_to(input int t);
      while (cyc < t - 1) step(0, 0, 0);
   endtask
   task automatic wr(input logic [31:0] a, input logic [7:0] d, input int fall);
      step(1, a, {24'hABCDEF, d});
      if (a == D) rdq.push_back('{32'h0, cyc + 1});
      if (fall != 0) txq.push_back('{d, fall});
   endtask
   task automatic rd(input logic [31:0] exp);
      step(0, S, 0);
      rdq.push_back('{exp, cyc + 1});
   endtask
   task automatic clr(input logic [31:0] exp);
      step(1, S, 32'hFFFF_FFFF);
      rdq.push_back('{exp, cyc + 1});
   endtask
   // Frame monitor: start bit seen at the first negedge after tx falls; every cycle of the frame is checked.
   initial begin
      logic prev, ok, abort, eb;
      logic [7:0] got;
      frm_t e;
      int fc;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset && prev && !tx) begin
            fc = cyc;
            if (txq.size() == 0) begin
               check("frame_unexpected", 32'(fc), 32'hFFFF_FFFF);
            end else begin
               e = txq.pop_front();
               ok = 1'b1;
               abort = 1'b0;
               got = '0;
               for (int i = 0; i < 40; i++) begin
                  if (i > 0) @(negedge clk);
                  if (reset) begin
                     abort = 1'b1;
                     break;
                  end
                  eb = i < 4 ? 1'b0 : i < 36 ? e.d[(i - 4) / 4] : 1'b1;
                  if (tx !== eb) ok = 1'b0;
                  if (i >= 4 && i < 36 && i % 4 == 2) got[(i - 4) / 4] = tx;
               end
               if (!abort) begin
                  check("frame_start_cycle", 32'(fc), 32'(e.c));
                  check("frame_byte", {23'h0, ok, got}, {23'h1, e.d});
               end
            end
         end
         prev = tx;
      end
   end
   initial begin
      rd_t r;
      forever begin
         @(negedge clk);
         if (sel) begin
            if (rdq.size() == 0) begin
               check("sel_stray", {31'h0, sel}, 32'h0);
            end else begin
               r = rdq.pop_front();
               check("rd_cycle", 32'(cyc), 32'(r.c));
               check("rd_data", RdData, r.v);
            end
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1;
      MemWrite = 0;
      DataAdr = 0;
      WriteData = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      check("reset_tx", {31'h0, tx}, 32'h1);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_sel", {31'h0, sel}, 32'h0);
      check("reset_rddata", RdData, 32'h0);
      rd(32'h4);
      // single byte A5
      m = cyc + 1;
      wr(D, 8'hA5, m + 2);
      step(0, 0, 0);
      check("busy_after_push", {31'h0, busy}, 32'h1);
      idle_to(m + 5);
      rd(32'h5);
      idle_to(m + 42);
      check("busy_end_of_stop", {31'h0, busy}, 32'h1);
      step(0, 0, 0);
      check("busy_drop", {31'h0, busy}, 32'h0);
      check("tx_idle", {31'h0, tx}, 32'h1);
      // burst
      idle_to(cyc + 8);
      m = cyc + 1;
      wr(D, 8'h01, m + 2);
      wr(D, 8'h02, m + 43);
      wr(D, 8'h03, m + 84);
      idle_to(m + 130);
      rd(32'h4);
      // overflow
      idle_to(cyc + 4);
      m = cyc + 1;
      wr(D, 8'h10, m + 2);
      for (int k = 1; k <= 8; k++) wr(D, 8'h10 + 8'(k), m + 2 + 41 * k);
      wr(D, 8'h19, 0);
      rd(32'h8B);
      clr(32'h8B);
      rd(32'h83);
      idle_to(m + 41);
      rd(32'h83);
      wr(D, 8'hEE, 0);
      rd(32'h79);
      idle_to(m + 375);
      clr(32'hC);
      rd(32'h4);
      // decode
      wr(D + 8, 8'h55, 0);
      wr(D - 4, 8'h66, 0);
      step(0, 0, 0);
      check("decode_sel", {31'h0, sel}, 32'h0);
      check("decode_rddata", RdData, 32'h0);
      rd(32'h4);
      // reset mid-frame
      idle_to(cyc + 4);
      m = cyc + 1;
      wr(D, 8'h00, m + 2);
      idle_to(m + 12);
      check("pre_reset_tx", {31'h0, tx}, 32'h0);
      #3 reset = 1;
      #1;
      check("async_reset_tx", {31'h0, tx}, 32'h1);
      check("async_reset_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      reset = 0;
      rd(32'h4);
      idle_to(cyc + 6);
      check("txq_drained", 32'(txq.size()), 32'h0);
      check("rdq_drained", 32'(rdq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
